bus_purifier_bank: RTL and testbench

Parametrised multi-channel successor to the single-signal bus debouncer. Takes `CHANNELS` asynchronous Vector-06c bus strobes, synchronises and shift-register-filters each one, and produces:

- clean levels and single-cycle rise/fall pulses;
- a runtime-selectable filter mode (follow-first-change or strict-settle);
- per-channel saturating glitch counters for bus-quality diagnostics.

It sits between the expansion-board pins and the bus decoders.

---
 rtl/bus_purifier_bank.sv | 130 +++++++++++++
 tb/tb_bus_purifier_bank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_purifier_bank.sv
// Multi-channel bus strobe purifier: per-channel two-flop synchroniser, shift-register
// filter, follow/strict settle FSM, clean edge pulses and saturating glitch counters.
module bus_purifier_bank #(
  parameter int                  CHANNELS  = 8,
  parameter int                  DEPTH     = 8,
  parameter int                  CNT_W     = 8,
  parameter logic [CHANNELS-1:0] RESET_LVL = {CHANNELS{1'b0}},
  localparam int                 SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  input  logic                mode,
  input  logic                clear_cnt,
  input  logic [SEL_W-1:0]    cnt_sel,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] settled,
  output logic [CNT_W-1:0]    glitch_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  logic [CNT_W-1:0] cnt_s [CHANNELS];
  logic [CNT_W-1:0] sel_cnt_s;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic             s1_r;
    logic             s2_r;
    logic [DEPTH-1:0] mem_r;
    logic             stable_s;
    logic             stable_r;
    logic             out_r;
    logic             out_prev_r;
    logic             entry_lvl_r;
    logic             settle_hit_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;

    assign stable_s     = (&mem_r) | ~(|mem_r);
    // A settle that lands back on the level held before the disturbance is a glitch.
    assign settle_hit_s = (state_r == ST_SETTLE) & stable_s & (mem_r[0] == entry_lvl_r);

    // Synchroniser, filter memory, delayed stability flag and edge history.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_r       <= RESET_LVL[ch];
        s2_r       <= RESET_LVL[ch];
        mem_r      <= {DEPTH{RESET_LVL[ch]}};
        stable_r   <= 1'b1;
        out_prev_r <= RESET_LVL[ch];
      end else begin
        s1_r       <= in[ch];
        s2_r       <= s1_r;
        mem_r      <= {mem_r[DEPTH-2:0], s2_r};
        stable_r   <= stable_s;
        out_prev_r <= out_r;
      end
    end

    // Settle FSM: leave IDLE on loss of stability, return once the filter is uniform again.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_r     <= ST_IDLE;
        out_r       <= RESET_LVL[ch];
        entry_lvl_r <= RESET_LVL[ch];
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (stable_r && !stable_s) begin
              entry_lvl_r <= out_r;
              state_r     <= ST_SETTLE;
              if (!mode) begin
                out_r <= s2_r;
              end
            end
          end
          ST_SETTLE: begin
            if (stable_s) begin
              out_r   <= mem_r[0];
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end

    // Saturating glitch counter; clear has priority over an increment.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (clear_cnt) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (settle_hit_s && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end

    assign out[ch]     = out_r;
    assign rise[ch]    = out_r & ~out_prev_r;
    assign fall[ch]    = ~out_r & out_prev_r;
    assign settled[ch] = (state_r == ST_IDLE);
    assign cnt_s[ch]   = cnt_r;
  end

  // Counter readout mux; selections beyond the last channel read as zero.
  always_comb begin
    sel_cnt_s = {CNT_W{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      sel_cnt_s = (cnt_sel == SEL_W'(i)) ? cnt_s[i] : sel_cnt_s;
    end
  end

  // Registered counter readout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_cnt <= {CNT_W{1'b0}};
    end else begin
      glitch_cnt <= sel_cnt_s;
    end
  end

endmodule

// File: tb/tb_bus_purifier_bank.sv
// Bench for bus_purifier_bank: table-driven step/pulse vectors, hand-written reset,
// saturation and clear sequences, and a randomized run against a sample-history model.
module tb_bus_purifier_bank;
  localparam int DEP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic [7:0] in_a = 8'h00;
  logic       mode_a = 1'b0, clear_a = 1'b0;
  logic [2:0] sel_a = 3'd0;
  logic [7:0] out_a, rise_a, fall_a, settled_a, gcnt_a;

  logic [5:0] in_b = 6'h00;
  logic       mode_b = 1'b1, clear_b = 1'b0;
  logic [2:0] sel_b = 3'd0;
  logic [5:0] out_b, rise_b, fall_b, settled_b;
  logic [1:0] gcnt_b;

  bus_purifier_bank dut_a (
    .clk(clk), .reset_n(reset_n), .in(in_a), .mode(mode_a), .clear_cnt(clear_a),
    .cnt_sel(sel_a), .out(out_a), .rise(rise_a), .fall(fall_a), .settled(settled_a),
    .glitch_cnt(gcnt_a)
  );

  bus_purifier_bank #(.CHANNELS(6), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in(in_b), .mode(mode_b), .clear_cnt(clear_b),
    .cnt_sel(sel_b), .out(out_b), .rise(rise_b), .fall(fall_b), .settled(settled_b),
    .glitch_cnt(gcnt_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: decisions derived from the history of sampled input words.
  logic [7:0] xq[$];
  logic [7:0] m_out, m_prev, m_busy, m_entry;
  int         m_cnt[8];
  int         m_gcnt;

  function automatic logic xbit(input int ch, input int k);
    logic [7:0] v;
    v = xq[xq.size() - 1 - k];
    return v[ch];
  endfunction

  // True when the samples k0..k1 edges back are all the same.
  function automatic bit hist_eq(input int ch, input int k0, input int k1);
    bit eq = 1'b1;
    for (int k = k0; k <= k1; k++) begin
      if (xbit(ch, k) != xbit(ch, k0)) eq = 1'b0;
    end
    return eq;
  endfunction

  task automatic model_reset();
    xq.delete();
    for (int i = 0; i < DEP + 4; i++) xq.push_back(8'h00);
    m_out = 8'h00; m_prev = 8'h00; m_busy = 8'h00; m_entry = 8'h00; m_gcnt = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step();
    bit now_st, was_st;
    xq.push_back(in_a);
    if (xq.size() > 40) void'(xq.pop_front());
    m_gcnt = m_cnt[sel_a];
    m_prev = m_out;
    for (int ch = 0; ch < 8; ch++) begin
      now_st = hist_eq(ch, 3, DEP + 2);
      was_st = hist_eq(ch, 4, DEP + 3);
      if (!m_busy[ch]) begin
        if (was_st && !now_st) begin
          m_entry[ch] = m_out[ch];
          m_busy[ch]  = 1'b1;
          if (!mode_a) m_out[ch] = xbit(ch, 2);
        end
      end else if (now_st) begin
        m_out[ch]  = xbit(ch, 3);
        m_busy[ch] = 1'b0;
        if (xbit(ch, 3) == m_entry[ch] && m_cnt[ch] < 255) m_cnt[ch]++;
      end
    end
    if (clear_a) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end
  endtask

  task automatic glitch_b(input int ch, input int width, input bit clr);
    int settle = width + DEP + 3;
    in_b[ch] = 1'b1;
    for (int e = 1; e <= settle + 4; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == width) in_b[ch] = 1'b0;
      clear_b = (clr && e == settle - 1);
    end
  endtask

  typedef struct {
    int   ch;
    logic mode;
    int   width;   // 0 = step and hold, otherwise pulse length in cycles
    int   tog;     // edge after which out flips (0 = never)
    int   ret;     // edge after which out flips back (0 = never)
    int   settle;  // edge after which settled returns
    int   inc;     // expected counter increment
  } vec_t;

  vec_t       vecs[10];
  vec_t       v;
  logic [7:0] lvl, exp_out, exp_rise, exp_fall, exp_set;
  logic       cur, prev_bit;
  int         exp_cnt[8];
  int         rate;

  initial begin
    vecs[0] = '{0, 1'b0, 0, 4, 0, 11, 0};
    vecs[1] = '{1, 1'b1, 0, 11, 0, 11, 0};
    vecs[2] = '{1, 1'b1, 3, 0, 0, 14, 1};
    vecs[3] = '{2, 1'b0, 3, 4, 14, 14, 1};
    vecs[4] = '{0, 1'b0, 0, 4, 0, 11, 0};
    vecs[5] = '{5, 1'b1, 1, 0, 0, 12, 1};
    vecs[6] = '{6, 1'b0, 1, 0, 0, 12, 1};
    vecs[7] = '{7, 1'b0, 2, 4, 13, 13, 1};
    vecs[8] = '{3, 1'b1, 5, 0, 0, 16, 1};
    vecs[9] = '{1, 1'b0, 0, 4, 0, 11, 0};
    for (int i = 0; i < 8; i++) exp_cnt[i] = 0;

    // Reset with all inputs high, then release between clock edges.
    in_a = 8'hFF;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset state", 64'({out_a, rise_a, fall_a, settled_a}), 64'({8'h00, 8'h00, 8'h00, 8'hFF}));
    check("reset cnt", 64'(gcnt_a), 64'd0);
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("release e%0d", e), 64'({out_a, rise_a, fall_a, settled_a}),
            64'({(e >= 4) ? 8'hFF : 8'h00, (e == 4) ? 8'hFF : 8'h00, 8'h00,
                 (e >= 4 && e < 11) ? 8'h00 : 8'hFF}));
    end
    in_a = 8'h00;
    repeat (16) @(negedge clk);
    check("back to zero", 64'({out_a, settled_a, gcnt_a}), 64'({8'h00, 8'hFF, 8'h00}));

    // Table of single-channel steps and pulses.
    lvl = 8'h00;
    for (int r = 0; r < 10; r++) begin
      v = vecs[r];
      mode_a = v.mode;
      sel_a = 3'(v.ch);
      in_a[v.ch] = ~lvl[v.ch];
      prev_bit = lvl[v.ch];
      for (int e = 1; e <= 24; e++) begin
        @(posedge clk); @(negedge clk);
        cur = lvl[v.ch] ^ ((v.tog != 0 && e >= v.tog && (v.ret == 0 || e < v.ret)) ? 1'b1 : 1'b0);
        exp_out = lvl; exp_out[v.ch] = cur;
        exp_rise = 8'h00; exp_rise[v.ch] = cur & ~prev_bit;
        exp_fall = 8'h00; exp_fall[v.ch] = ~cur & prev_bit;
        exp_set = 8'hFF; exp_set[v.ch] = !(e >= 4 && e < v.settle);
        check($sformatf("vec%0d e%0d", r, e), 64'({out_a, rise_a, fall_a, settled_a}),
              64'({exp_out, exp_rise, exp_fall, exp_set}));
        prev_bit = cur;
        if (v.width != 0 && e == v.width) in_a[v.ch] = lvl[v.ch];
      end
      if (v.width == 0) lvl[v.ch] = ~lvl[v.ch];
      exp_cnt[v.ch] += v.inc;
      check($sformatf("vec%0d cnt", r), 64'(gcnt_a), 64'(exp_cnt[v.ch]));
    end

    // Narrow counter: saturation, out-of-range select, clear against increment.
    sel_b = 3'd3;
    for (int g = 1; g <= 5; g++) begin
      glitch_b(3, 3, 1'b0);
      check($sformatf("b glitch%0d cnt", g), 64'(gcnt_b), 64'((g < 3) ? g : 3));
      check($sformatf("b glitch%0d out", g), 64'(out_b), 64'd0);
    end
    sel_b = 3'd7;
    #1;
    check("b sel lag", 64'(gcnt_b), 64'd3);
    @(posedge clk); @(negedge clk);
    check("b sel 7", 64'(gcnt_b), 64'd0);
    sel_b = 3'd6;
    @(posedge clk); @(negedge clk);
    check("b sel 6", 64'(gcnt_b), 64'd0);
    sel_b = 3'd3;
    @(posedge clk); @(negedge clk);
    check("b sel 3", 64'(gcnt_b), 64'd3);
    glitch_b(3, 3, 1'b1);
    check("b clear sat", 64'(gcnt_b), 64'd0);
    glitch_b(3, 3, 1'b0);
    check("b after clear", 64'(gcnt_b), 64'd1);
    glitch_b(3, 3, 1'b1);
    check("b clear wins", 64'(gcnt_b), 64'd0);

    // Reset while channel 4 is mid-settle with out already high.
    mode_a = 1'b0;
    sel_a = 3'd2;
    in_a[4] = 1'b1;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    check("pre reset", 64'({out_a[4], settled_a[4], gcnt_a}), 64'({1'b1, 1'b0, 8'(exp_cnt[2])}));
    in_a[4] = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid reset", 64'({out_a, rise_a, fall_a, settled_a, gcnt_a}),
          64'({8'h00, 8'h00, 8'h00, 8'hFF, 8'h00}));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("post reset e%0d", e), 64'({out_a, fall_a, gcnt_a}), 64'd0);
    end

    // Randomized run against the model.
    model_reset();
    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(3, 0))
        0:       rate = 2;
        1:       rate = 4;
        2:       rate = 10;
        default: rate = 40;
      endcase
      mode_a = 1'($urandom_range(1, 0));
      for (int c = 0; c < 50; c++) begin
        for (int ch = 0; ch < 8; ch++) begin
          if ($urandom_range(rate - 1, 0) == 0) in_a[ch] = ~in_a[ch];
        end
        if ($urandom_range(15, 0) == 0) mode_a = ~mode_a;
        clear_a = ($urandom_range(63, 0) == 0);
        sel_a = 3'($urandom_range(7, 0));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check($sformatf("random s%0d c%0d", seg, c),
              64'({out_a, rise_a, fall_a, settled_a, gcnt_a}),
              64'({m_out, m_out & ~m_prev, ~m_out & m_prev, ~m_busy, 8'(m_gcnt)}));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
